// File: rtl/diaosi_types_pkg.sv
// Shared types and constants for the pipeline control slice.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
//
// Contents: regbits_t (register index), word_t (32-bit word),
// pctrl_state_t (pipeline controller FSM states), DRAIN_CYCLES.
package diaosi_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctrl_state_t;

  // Cycles spent letting older instructions retire after a halt reaches MEM.
  localparam int DRAIN_CYCLES = 2;
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detect: load in EX writes a register that ID is reading.
// Latency: combinational, zero cycles.
// Backpressure: none; pure compare, the controller decides how to stall.
//
// Ports:
//   ld_ex      - ID/EX latch holds a load
//   ld_wsel_ex - destination register of that load
//   rsel1_id   - first source register decoded in ID
//   rsel2_id   - second source register decoded in ID
//   lu_hz      - hazard present
module load_use_detect
  import diaosi_types_pkg::*;
(
  input  logic     ld_ex,
  input  regbits_t ld_wsel_ex,
  input  regbits_t rsel1_id,
  input  regbits_t rsel2_id,
  output logic     lu_hz
);

  logic w_nonzero;
  logic w_match;

  // Register 0 is hardwired to zero, so a load targeting it never hazards.
  assign w_nonzero = (ld_wsel_ex != '0);
  assign w_match   = (ld_wsel_ex == rsel1_id) | (ld_wsel_ex == rsel2_id);
  assign lu_hz     = ld_ex & w_nonzero & w_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: latch enables, bubble inserts, halt drain, stall counter.
// Latency: all control outputs combinational from state and inputs.
// Backpressure: dmem miss freezes every stage; load-use/ifetch miss stall front.
//
// Ports:
//   CLK, RST              - clock, synchronous active-high reset
//   ihit, dhit, dreq_mem  - fetch valid, data access done, MEM holds ld/st
//   ld_ex, ld_wsel_ex     - load in EX and its destination register
//   rsel1_id, rsel2_id    - ID source registers
//   br_taken, halt_mem    - taken branch at EX/MEM, halt at MEM
//   pc_en..wb_en          - stage latch enables
//   hz_flushed1/2, flushed- bubble insert into IF/ID, ID/EX, EX/MEM
//   halt_out              - pipeline halted
//   stall_cycles          - cycles with PC held (only with PIPE_STALL_CNT_EN)
// Optional build macro: PIPE_STALL_CNT_EN enables the stall cycle counter.
module pipeline_ctrl
  import diaosi_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dreq_mem,
  input  logic     ld_ex,
  input  regbits_t ld_wsel_ex,
  input  regbits_t rsel1_id,
  input  regbits_t rsel2_id,
  input  logic     br_taken,
  input  logic     halt_mem,
  output logic     pc_en,
  output logic     id_en1,
  output logic     id_en2,
  output logic     en,
  output logic     wb_en,
  output logic     hz_flushed1,
  output logic     hz_flushed2,
  output logic     flushed,
  output logic     halt_out,
  output word_t    stall_cycles
);

  pctrl_state_t r_state;
  pctrl_state_t w_next_state;
  logic [1:0]   r_drain_cnt;
  logic         w_lu_hz;

  // Flow response when no miss/halt is pending: branch beats load-use beats
  // fetch miss. ID/EX, EX/MEM and MEM/WB always advance in this case.
  logic w_f_pc_en;
  logic w_f_id_en1;
  logic w_f_fl1;
  logic w_f_fl2;
  logic w_f_fl3;

  load_use_detect u_lud (
    .ld_ex      (ld_ex),
    .ld_wsel_ex (ld_wsel_ex),
    .rsel1_id   (rsel1_id),
    .rsel2_id   (rsel2_id),
    .lu_hz      (w_lu_hz)
  );

  always_comb begin
    w_f_pc_en  = 1'b1;
    w_f_id_en1 = 1'b1;
    w_f_fl1    = 1'b0;
    w_f_fl2    = 1'b0;
    w_f_fl3    = 1'b0;
    if (br_taken) begin
      // Squash the three younger instructions; the load-use stall is moot.
      w_f_fl1 = 1'b1;
      w_f_fl2 = 1'b1;
      w_f_fl3 = 1'b1;
    end else if (w_lu_hz) begin
      // Hold IF/ID and PC, send a bubble into EX; the load moves on next cycle.
      w_f_pc_en  = 1'b0;
      w_f_id_en1 = 1'b0;
      w_f_fl2    = 1'b1;
    end else if (!ihit) begin
      w_f_pc_en = 1'b0;
      w_f_fl1   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DRAIN && r_drain_cnt != DRAIN_LAST) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    pc_en        = 1'b0;
    id_en1       = 1'b0;
    id_en2       = 1'b0;
    en           = 1'b0;
    wb_en        = 1'b0;
    hz_flushed1  = 1'b0;
    hz_flushed2  = 1'b0;
    flushed      = 1'b0;
    halt_out     = 1'b0;
    if (!RST) begin
      case (r_state)
        RUN: begin
          if (halt_mem) begin
            // Let the halt and older instructions move on, kill everything younger.
            id_en1       = 1'b1;
            id_en2       = 1'b1;
            en           = 1'b1;
            wb_en        = 1'b1;
            hz_flushed1  = 1'b1;
            hz_flushed2  = 1'b1;
            flushed      = 1'b1;
            w_next_state = DRAIN;
          end else if (dreq_mem && !dhit) begin
            w_next_state = DWAIT;
          end else begin
            pc_en       = w_f_pc_en;
            id_en1      = w_f_id_en1;
            id_en2      = 1'b1;
            en          = 1'b1;
            wb_en       = 1'b1;
            hz_flushed1 = w_f_fl1;
            hz_flushed2 = w_f_fl2;
            flushed     = w_f_fl3;
          end
        end
        DWAIT: begin
          // halt_mem is deliberately not looked at until the access completes.
          if (dhit) begin
            pc_en        = w_f_pc_en;
            id_en1       = w_f_id_en1;
            id_en2       = 1'b1;
            en           = 1'b1;
            wb_en        = 1'b1;
            hz_flushed1  = w_f_fl1;
            hz_flushed2  = w_f_fl2;
            flushed      = w_f_fl3;
            w_next_state = RUN;
          end
        end
        DRAIN: begin
          en    = 1'b1;
          wb_en = 1'b1;
          if (r_drain_cnt == DRAIN_LAST) begin
            w_next_state = HALTED;
          end
        end
        HALTED: begin
          halt_out = 1'b1;
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  word_t r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (!pc_en && r_state != HALTED && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
